stump_mem_arbiter: RTL and testbench

Shares the Stump processor's single-port synchronous memory between the core's load/store/fetch port and an external requester (debug/DMA loader). The block sits between the Stump control/datapath memory interface and the memory model. It grants at most one access per cycle and registers the winning access onto the memory port. It routes read data back to the owner, and an optional starvation counter keeps the external port from being locked out.

---
 rtl/stump_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_stump_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stump_mem_arbiter.sv
// Arbitrates the Stump core and an external requester onto one single-port synchronous memory.
// Build option: define STUMP_ARB_STARVE_EN to let a waiting ext port break core priority.
module stump_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_wen,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_rd_owner,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    // Handshake: a requester raises req with wen/addr/wdata and holds them stable until the
    // cycle its gnt is 1; that cycle is the transfer, and req may drop or change afterwards.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    owner_t rd_owner_q;
    owner_t rd_owner_d;
    logic   starve_force;
    logic   any_gnt;
    logic   sel_wen;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef STUMP_ARB_STARVE_EN
    logic [CNT_W-1:0] starve_cnt;

    // Counts core wins while ext is kept waiting; ext wins at the limit, so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!ext_req || ext_gnt) begin
            starve_cnt <= '0;
        end else if (core_gnt && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starve_force   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign dbg_starve_cnt = starve_cnt;
`else
    assign starve_force   = 1'b0;
    assign dbg_starve_cnt = '0;
`endif

    assign core_gnt = rst && core_req && !(ext_req && starve_force);
    assign ext_gnt  = rst && ext_req && (!core_req || starve_force);
    assign any_gnt  = core_gnt || ext_gnt;

    always_comb begin
        sel_wen    = ext_wen;
        sel_addr   = ext_addr;
        sel_wdata  = ext_wdata;
        rd_owner_d = OWN_NONE;
        if (core_gnt) begin
            sel_wen   = core_wen;
            sel_addr  = core_addr;
            sel_wdata = core_wdata;
            if (!core_wen) rd_owner_d = OWN_CORE;
        end else if (ext_gnt && !ext_wen) begin
            rd_owner_d = OWN_EXT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en      <= 1'b0;
            mem_wen     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_owner_q  <= OWN_NONE;
            busy        <= 1'b0;
            core_rvalid <= 1'b0;
            ext_rvalid  <= 1'b0;
            core_rdata  <= '0;
            ext_rdata   <= '0;
        end else begin
            mem_en     <= any_gnt;
            mem_wen    <= any_gnt && sel_wen;
            rd_owner_q <= rd_owner_d;
            busy       <= (rd_owner_d != OWN_NONE);
            if (any_gnt) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            // Memory answers during the cycle after mem_en; capture it for the read's owner.
            core_rvalid <= (rd_owner_q == OWN_CORE);
            ext_rvalid  <= (rd_owner_q == OWN_EXT);
            if (rd_owner_q == OWN_CORE) core_rdata <= mem_rdata;
            if (rd_owner_q == OWN_EXT)  ext_rdata  <= mem_rdata;
        end
    end

    assign dbg_rd_owner = rd_owner_q;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Randomized and directed bench for stump_mem_arbiter against a grant-order memory model.
module tb_stump_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LIM = 4;
    localparam int CW  = $clog2(LIM + 1);
`ifdef STUMP_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk, rst;
    logic          core_req, core_wen, core_gnt, core_rvalid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          ext_req, ext_wen, ext_gnt, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          mem_en, mem_wen, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    dbg_rd_owner;
    logic [CW-1:0] dbg_starve_cnt;

    stump_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_wen(core_wen), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy),
        .dbg_rd_owner(dbg_rd_owner), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // ---------------- clock / reset / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem    [0:255];
    logic [DW-1:0] shadow [0:255];
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_en && mem_wen) mem[mem_addr[7:0]] <= mem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int            due;
        bit            is_ext;
        logic [DW-1:0] data;
    } rd_t;
    rd_t exp_q[$];
    rd_t r;

    int            cyc = 0;
    int            waits;
    bit            force_ext, exp_cg, exp_eg, exp_crv, exp_erv, exp_busy, w;
    logic          exp_en, exp_wen;
    logic [AW-1:0] exp_addr, a;
    logic [DW-1:0] exp_wdata, exp_crd, exp_erd, d;

    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst) begin
            check("rst_ctrl", {mem_en, mem_wen, core_rvalid, ext_rvalid, busy, core_gnt, ext_gnt}, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_rdata", {core_rdata, ext_rdata}, 0);
            check("rst_starve_cnt", dbg_starve_cnt, 0);
            exp_q.delete();
            waits = 0; exp_en = 0; exp_wen = 0; exp_addr = '0; exp_wdata = '0;
            exp_crd = '0; exp_erd = '0;
        end else begin
            force_ext = STARVE_EN && (waits == LIM);
            exp_cg = core_req && !(ext_req && force_ext);
            exp_eg = ext_req && (!core_req || force_ext);
            exp_crv = 0;
            exp_erv = 0;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                r = exp_q.pop_front();
                if (r.is_ext) begin exp_erv = 1; exp_erd = r.data; end
                else begin exp_crv = 1; exp_crd = r.data; end
            end
            exp_busy = (exp_q.size() > 0) && (exp_q[exp_q.size()-1].due == cyc + 1);
            check("core_gnt", core_gnt, exp_cg);
            check("ext_gnt", ext_gnt, exp_eg);
            check("mem_en", mem_en, exp_en);
            check("mem_wen", mem_wen, exp_wen);
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wdata", mem_wdata, exp_wdata);
            check("core_rvalid", core_rvalid, exp_crv);
            check("ext_rvalid", ext_rvalid, exp_erv);
            check("core_rdata", core_rdata, exp_crd);
            check("ext_rdata", ext_rdata, exp_erd);
            check("busy", busy, exp_busy);
            check("starve_cnt", dbg_starve_cnt, waits);
            // Reads see every write granted before them, in grant order.
            if (exp_cg || exp_eg) begin
                w = exp_cg ? core_wen : ext_wen;
                a = exp_cg ? core_addr : ext_addr;
                d = exp_cg ? core_wdata : ext_wdata;
                exp_en = 1; exp_wen = w; exp_addr = a; exp_wdata = d;
                if (w) shadow[a[7:0]] = d;
                else exp_q.push_back('{due: cyc + 2, is_ext: exp_eg, data: shadow[a[7:0]]});
            end else begin
                exp_en = 0;
                exp_wen = 0;
            end
            if (!ext_req || exp_eg) waits = 0;
            else if (exp_cg && STARVE_EN) waits++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_core(input bit req, input bit wen, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        core_req = req; core_wen = wen; core_addr = ad; core_wdata = wd;
    endtask

    task automatic drive_ext(input bit req, input bit wen, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        ext_req = req; ext_wen = wen; ext_addr = ad; ext_wdata = wd;
    endtask

    task automatic idle();
        core_req = 1'b0;
        ext_req  = 1'b0;
    endtask

    task automatic rand_side(input int pct, inout logic req, inout logic wen,
                             inout logic [AW-1:0] ad, inout logic [DW-1:0] wd, input logic gnt);
        if (!(req && !gnt)) begin
            req = ($urandom_range(0, 99) < pct);
            wen = ($urandom_range(0, 2) == 0);
            ad  = AW'($urandom_range(0, 15));
            wd  = DW'($urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    bit ext_done;
    int pct;

    initial begin
        rst = 1'b0;
        drive_core(0, 0, '0, '0);
        drive_ext(0, 0, '0, '0);
        for (int i = 0; i < 256; i++) begin
            mem[i] = DW'($urandom);
            shadow[i] = mem[i];
        end
        mem[8'h10] = 16'hBEEF; mem[8'h01] = 16'h0A0A; mem[8'h02] = 16'h0B0B;
        mem[8'h03] = 16'h3333; mem[8'h04] = 16'h4444; mem[8'h05] = 16'h5555;
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Core read alone
        @(negedge clk); drive_core(1, 0, 16'h0010, 0); #3 check("t1_core_gnt", core_gnt, 1);
        @(negedge clk); idle(); #3;
        check("t1_mem_en", mem_en, 1); check("t1_mem_wen", mem_wen, 0); check("t1_mem_addr", mem_addr, 16'h0010);
        @(negedge clk); #3;
        check("t1_core_rvalid", core_rvalid, 1); check("t1_core_rdata", core_rdata, 16'hBEEF);
        check("t1_ext_rvalid", ext_rvalid, 0);

        // Ext write alone, then core reads it back
        @(negedge clk); drive_ext(1, 1, 16'h0020, 16'h1234); #3 check("t2_ext_gnt", ext_gnt, 1);
        @(negedge clk); idle(); #3;
        check("t2_mem_wen", mem_wen, 1); check("t2_mem_wdata", mem_wdata, 16'h1234);
        @(negedge clk); #3 check("t2_no_rvalid", {core_rvalid, ext_rvalid}, 0);
        @(negedge clk); drive_core(1, 0, 16'h0020, 0);
        @(negedge clk); idle();
        @(negedge clk); #3;
        check("t2_rb_rvalid", core_rvalid, 1); check("t2_rb_rdata", core_rdata, 16'h1234);

        // Contention held continuously
        ext_done = 0;
        @(negedge clk);
        drive_core(1, 0, 16'h0003, 0);
        drive_ext(1, 0, 16'h0004, 0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (ext_done) ext_req = 1'b0;
            #3;
            check("t3_core_gnt", core_gnt, STARVE_EN ? (i != 4) : 1);
            check("t3_ext_gnt", ext_gnt, STARVE_EN ? (i == 4) : 0);
            if (i == 4) check("t3_starve_cnt", dbg_starve_cnt, STARVE_EN ? 4 : 0);
            if (ext_gnt) ext_done = 1;
        end
        @(negedge clk); idle();
        repeat (2) @(negedge clk);

        // Interleaved reads
        @(negedge clk); drive_core(1, 0, 16'h0001, 0); #3 check("t4_busy_c0", busy, 0);
        @(negedge clk); idle(); drive_ext(1, 0, 16'h0002, 0); #3 check("t4_busy_c1", busy, 1);
        @(negedge clk); idle(); #3;
        check("t4_busy_c2", busy, 1); check("t4_core_rvalid", core_rvalid, 1);
        check("t4_core_rdata", core_rdata, 16'h0A0A); check("t4_ext_rvalid_c2", ext_rvalid, 0);
        @(negedge clk); #3;
        check("t4_ext_rvalid", ext_rvalid, 1); check("t4_ext_rdata", ext_rdata, 16'h0B0B);
        check("t4_core_rvalid_c3", core_rvalid, 0); check("t4_busy_c3", busy, 0);

        // Reset in the middle of a read
        @(negedge clk); drive_core(1, 0, 16'h0003, 0);
        @(negedge clk); idle(); rst = 1'b0; #3;
        check("t5_mem_en", mem_en, 0); check("t5_busy", busy, 0);
        check("t5_mem_addr", mem_addr, 0); check("t5_starve_cnt", dbg_starve_cnt, 0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #3 check("t5_no_rvalid", core_rvalid, 0);
        end

        // Back-to-back core reads
        @(negedge clk); drive_core(1, 0, 16'h0003, 0);
        @(negedge clk); drive_core(1, 0, 16'h0004, 0);
        @(negedge clk); drive_core(1, 0, 16'h0005, 0); #3;
        check("t6_rvalid0", core_rvalid, 1); check("t6_rdata0", core_rdata, 16'h3333);
        @(negedge clk); idle(); #3;
        check("t6_rvalid1", core_rvalid, 1); check("t6_rdata1", core_rdata, 16'h4444);
        @(negedge clk); #3;
        check("t6_rvalid2", core_rvalid, 1); check("t6_rdata2", core_rdata, 16'h5555);
        @(negedge clk); #3 check("t6_rvalid_end", core_rvalid, 0);

        // Random traffic with a heavy-contention window and one mid-run reset
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            pct = (n >= 100 && n < 160) ? 90 : 50;
            rand_side(pct, core_req, core_wen, core_addr, core_wdata, core_gnt);
            rand_side(pct, ext_req, ext_wen, ext_addr, ext_wdata, ext_gnt);
            if (n == 250) rst = 1'b0;
            if (n == 252) rst = 1'b1;
        end
        @(negedge clk); idle();
        repeat (4) @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
